// File: rtl/layer_controller_if.sv
// Bundles the image-run control, pixel stream, hidden-layer link and result
// handshake of the layer controller. The master modport is the controller's
// view and the slave modport is the surrounding environment's view.
interface layer_controller_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         start;
    logic                         abort;
    logic [1:0]                   activation_cfg;
    logic                         pixel_valid;
    logic signed [DATA_WIDTH-1:0] pixel_in;
    logic                         pixel_ready;
    logic                         layer_start;
    logic                         layer_data_valid;
    logic signed [DATA_WIDTH-1:0] layer_pixel;
    logic [1:0]                   layer_activation_type;
    logic signed [DATA_WIDTH-1:0] layer_out_n0;
    logic signed [DATA_WIDTH-1:0] layer_out_n1;
    logic signed [DATA_WIDTH-1:0] layer_out_n2;
    logic signed [DATA_WIDTH-1:0] layer_out_n3;
    logic signed [DATA_WIDTH-1:0] result_n0;
    logic signed [DATA_WIDTH-1:0] result_n1;
    logic signed [DATA_WIDTH-1:0] result_n2;
    logic signed [DATA_WIDTH-1:0] result_n3;
    logic                         result_valid;
    logic                         result_ready;
    logic                         busy;
    logic                         done;
    logic [7:0]                   pixel_count;

    modport master (
        input  start, abort, activation_cfg, pixel_valid, pixel_in,
        input  layer_out_n0, layer_out_n1, layer_out_n2, layer_out_n3,
        input  result_ready,
        output pixel_ready, layer_start, layer_data_valid, layer_pixel,
        output layer_activation_type,
        output result_n0, result_n1, result_n2, result_n3,
        output result_valid, busy, done, pixel_count
    );

    modport slave (
        output start, abort, activation_cfg, pixel_valid, pixel_in,
        output layer_out_n0, layer_out_n1, layer_out_n2, layer_out_n3,
        output result_ready,
        input  pixel_ready, layer_start, layer_data_valid, layer_pixel,
        input  layer_activation_type,
        input  result_n0, result_n1, result_n2, result_n3,
        input  result_valid, busy, done, pixel_count
    );
endinterface

// File: rtl/layer_controller.sv
// Sequences one image through the hidden layer: clears it, streams
// NUM_PIXELS pixels into it, captures the four activated neuron outputs one
// cycle after the last pixel and holds them until the consumer takes them.
module layer_controller #(
    parameter int NUM_PIXELS = 64,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    layer_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, SETTLE, RESULT} state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_PIXELS - 1);

    state_t                       state_q, state_d;
    logic [7:0]                   count_q, count_d;
    logic [1:0]                   act_q, act_d;
    logic signed [DATA_WIDTH-1:0] res0_q, res0_d;
    logic signed [DATA_WIDTH-1:0] res1_q, res1_d;
    logic signed [DATA_WIDTH-1:0] res2_q, res2_d;
    logic signed [DATA_WIDTH-1:0] res3_q, res3_d;
    logic                         accept;

    assign accept = (state_q == STREAM) && bus.pixel_valid;

    // State and datapath registers; reset also clears the captured scores.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            act_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
            res3_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            act_q   <= act_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            res3_q  <= res3_d;
        end
    end

    // Next-state logic; abort outside IDLE wins over every other update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        act_d   = act_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        res3_d  = res3_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) state_d = CLEAR;
            end
            CLEAR: begin
                count_d = '0;
                act_d   = bus.activation_cfg;
                state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    // Saturate so a 256-pixel image ends at 255 rather than wrapping.
                    count_d = (count_q == 8'hFF) ? count_q : 8'(count_q + 8'd1);
                    if (count_q == LAST_IDX) state_d = SETTLE;
                end
            end
            SETTLE: begin
                res0_d  = bus.layer_out_n0;
                res1_d  = bus.layer_out_n1;
                res2_d  = bus.layer_out_n2;
                res3_d  = bus.layer_out_n3;
                state_d = RESULT;
            end
            RESULT: begin
                if (bus.result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            count_d = count_q;
            act_d   = act_q;
            res0_d  = res0_q;
            res1_d  = res1_q;
            res2_d  = res2_q;
            res3_d  = res3_q;
        end
    end

    // Output decode; every output is forced low while reset is held.
    always_comb begin
        bus.pixel_ready           = 1'b0;
        bus.layer_start           = 1'b0;
        bus.layer_data_valid      = 1'b0;
        bus.layer_pixel           = '0;
        bus.layer_activation_type = '0;
        bus.result_n0             = '0;
        bus.result_n1             = '0;
        bus.result_n2             = '0;
        bus.result_n3             = '0;
        bus.result_valid          = 1'b0;
        bus.busy                  = 1'b0;
        bus.done                  = 1'b0;
        bus.pixel_count           = '0;
        if (!reset) begin
            bus.busy                  = (state_q != IDLE);
            bus.layer_start           = (state_q == CLEAR);
            bus.pixel_ready           = (state_q == STREAM);
            bus.layer_data_valid      = accept;
            bus.layer_pixel           = (state_q == STREAM) ? bus.pixel_in : '0;
            bus.result_valid          = (state_q == RESULT);
            bus.done                  = (state_q == RESULT) && bus.result_ready && !bus.abort;
            bus.layer_activation_type = act_q;
            bus.pixel_count           = count_q;
            bus.result_n0             = res0_q;
            bus.result_n1             = res1_q;
            bus.result_n2             = res2_q;
            bus.result_n3             = res3_q;
        end
    end
endmodule

// File: tb/tb_layer_controller.sv
// Self-checking bench for layer_controller with a four-pixel image.
module tb_layer_controller;
    localparam int NP = 4;

    typedef struct packed {
        logic [7:0] n0;
        logic [7:0] n1;
        logic [7:0] n2;
        logic [7:0] n3;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   strobes = 0;
    int   starts  = 0;
    logic signed [7:0] pix_q[$];
    res_t              res_q[$];
    res_t              last_res = '0;
    logic signed [7:0] mon_exp;

    layer_controller_if #(.DATA_WIDTH(8)) bus ();

    layer_controller #(.NUM_PIXELS(NP), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t got_res();
        return {bus.result_n0, bus.result_n1, bus.result_n2, bus.result_n3};
    endfunction

    function automatic logic [55:0] all_outs();
        return {bus.pixel_ready, bus.layer_start, bus.layer_data_valid, bus.layer_pixel,
                bus.layer_activation_type, bus.result_n0, bus.result_n1, bus.result_n2,
                bus.result_n3, bus.result_valid, bus.busy, bus.done, bus.pixel_count};
    endfunction

    // Strobe scoreboard: every strobe must carry the next pixel the bench fed.
    always @(negedge clk) begin
        if (bus.layer_start === 1'b1) starts++;
        if (bus.layer_data_valid === 1'b1) begin
            strobes++;
            total++;
            if (pix_q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected got pixel=%0d required no strobe", bus.layer_pixel);
            end else begin
                mon_exp = pix_q.pop_front();
                if (bus.layer_pixel !== mon_exp) begin
                    bad++;
                    $display("FAIL strobe_pixel got=%0d required=%0d", bus.layer_pixel, mon_exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] cfg);
        bus.activation_cfg = cfg;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
    endtask

    task automatic feed(input logic signed [7:0] v);
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = v;
        pix_q.push_back(v);
    endtask

    task automatic idle_in();
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = 8'sh5A;
    endtask

    task automatic stub(input res_t r);
        bus.layer_out_n0 = r.n0;
        bus.layer_out_n1 = r.n1;
        bus.layer_out_n2 = r.n2;
        bus.layer_out_n3 = r.n3;
        res_q.push_back(r);
    endtask

    task automatic junk();
        bus.layer_out_n0 = 8'sh77;
        bus.layer_out_n1 = 8'sh66;
        bus.layer_out_n2 = 8'sh55;
        bus.layer_out_n3 = 8'sh44;
    endtask

    task automatic test_reset();
        res_t r;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.pixel_valid = 1'b1;
        bus.pixel_in = 8'sh33;
        bus.activation_cfg = 2'b11;
        bus.result_ready = 1'b1;
        cyc();
        @(negedge clk);
        total++;
        if (all_outs() !== 56'd0) begin
            bad++;
            $display("FAIL reset_held_outputs got=%h required=0", all_outs());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.start = 1'b0;
        idle_in();
        bus.result_ready = 1'b0;
        bus.activation_cfg = 2'b00;
        @(negedge clk);
        total++;
        if (all_outs() !== 56'd0) begin
            bad++;
            $display("FAIL reset_idle_state got=%h required=0", all_outs());
        end
        r = got_res();
        total++;
        if (starts !== 0 || r !== 32'd0) begin
            bad++;
            $display("FAIL reset_no_start got starts=%0d res=%h required 0/0", starts, r);
        end
    endtask

    task automatic test_basic();
        int s0 = strobes;
        int l0 = starts;
        res_t r, e;
        cyc();
        bus.activation_cfg = 2'b01;
        bus.start = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.layer_start, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL basic_idle got ls/busy=%b required 00", {bus.layer_start, bus.busy});
        end
        cyc();
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.layer_start, bus.busy, bus.pixel_ready} !== 3'b110) begin
            bad++;
            $display("FAIL basic_clear got ls/busy/prdy=%b required 110",
                     {bus.layer_start, bus.busy, bus.pixel_ready});
        end
        cyc();
        for (int i = 0; i < NP; i++) begin
            feed(8'(i + 1));
            @(negedge clk);
            total++;
            if ({bus.pixel_ready, bus.layer_start, bus.pixel_count, bus.layer_activation_type}
                !== {1'b1, 1'b0, 8'(i), 2'b01}) begin
                bad++;
                $display("FAIL basic_stream%0d got prdy=%b ls=%b cnt=%0d act=%b required 1 0 %0d 01",
                         i, bus.pixel_ready, bus.layer_start, bus.pixel_count,
                         bus.layer_activation_type, i);
            end
            cyc();
        end
        idle_in();
        stub({8'h2A, 8'h01, 8'hF0, 8'h00});
        @(negedge clk);
        total++;
        if ({bus.result_valid, bus.pixel_ready, bus.pixel_count, bus.layer_pixel} !== {2'b00, 8'd4, 8'd0}) begin
            bad++;
            $display("FAIL basic_settle got rv=%b prdy=%b cnt=%0d lpix=%0d required 0 0 4 0",
                     bus.result_valid, bus.pixel_ready, bus.pixel_count, bus.layer_pixel);
        end
        cyc();
        junk();
        bus.result_ready = 1'b1;
        @(negedge clk);
        e = res_q.pop_front();
        r = got_res();
        total++;
        if ({bus.result_valid, bus.done, r} !== {2'b11, e}) begin
            bad++;
            $display("FAIL basic_result got rv=%b done=%b res=%h required 1 1 %h",
                     bus.result_valid, bus.done, r, e);
        end
        last_res = e;
        cyc();
        bus.result_ready = 1'b0;
        @(negedge clk);
        r = got_res();
        total++;
        if ({bus.result_valid, bus.done, bus.busy, r} !== {3'b000, e}) begin
            bad++;
            $display("FAIL basic_after got rv=%b done=%b busy=%b res=%h required 0 0 0 %h",
                     bus.result_valid, bus.done, bus.busy, r, e);
        end
        total++;
        if ((strobes - s0) !== NP || (starts - l0) !== 1) begin
            bad++;
            $display("FAIL basic_counts got strobes=%0d starts=%0d required %0d 1",
                     strobes - s0, starts - l0, NP);
        end
    endtask

    task automatic test_gapped();
        int s0 = strobes;
        int k = 0;
        bit pat [7];
        res_t r, e;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cyc();
        start_run(2'b00);
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) feed(8'(20 + i));
            else idle_in();
            @(negedge clk);
            total++;
            if ({bus.pixel_ready, bus.result_valid, bus.pixel_count} !== {2'b10, 8'(k)}) begin
                bad++;
                $display("FAIL gap_step%0d got prdy=%b rv=%b cnt=%0d required 1 0 %0d",
                         i, bus.pixel_ready, bus.result_valid, bus.pixel_count, k);
            end
            if (pat[i]) k++;
            cyc();
        end
        idle_in();
        stub({8'h11, 8'h22, 8'h33, 8'h44});
        @(negedge clk);
        total++;
        if ({bus.pixel_ready, bus.busy, bus.pixel_count} !== {2'b01, 8'd4}) begin
            bad++;
            $display("FAIL gap_settle got prdy=%b busy=%b cnt=%0d required 0 1 4",
                     bus.pixel_ready, bus.busy, bus.pixel_count);
        end
        cyc();
        junk();
        bus.result_ready = 1'b1;
        @(negedge clk);
        e = res_q.pop_front();
        r = got_res();
        total++;
        if ({bus.result_valid, bus.done, r} !== {2'b11, e} || (strobes - s0) !== 4) begin
            bad++;
            $display("FAIL gap_result got rv=%b done=%b res=%h strobes=%0d required 1 1 %h 4",
                     bus.result_valid, bus.done, r, strobes - s0, e);
        end
        last_res = e;
        cyc();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int l0 = starts;
        res_t r, e;
        cyc();
        start_run(2'b01);
        for (int i = 0; i < NP; i++) begin
            feed(8'(-3 * i));
            cyc();
        end
        idle_in();
        stub({8'hFB, 8'h07, 8'h80, 8'h7F});
        cyc();
        junk();
        e = res_q[0];
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 3 || i == 6);
            @(negedge clk);
            r = got_res();
            total++;
            if ({bus.result_valid, bus.done, bus.pixel_ready, bus.layer_pixel, r}
                !== {3'b100, 8'd0, e}) begin
                bad++;
                $display("FAIL bp_hold%0d got rv=%b done=%b prdy=%b lpix=%0d res=%h required 1 0 0 0 %h",
                         i, bus.result_valid, bus.done, bus.pixel_ready, bus.layer_pixel, r, e);
            end
            cyc();
        end
        bus.start = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        e = res_q.pop_front();
        r = got_res();
        total++;
        if ({bus.result_valid, bus.done, r} !== {2'b11, e}) begin
            bad++;
            $display("FAIL bp_release got rv=%b done=%b res=%h required 1 1 %h",
                     bus.result_valid, bus.done, r, e);
        end
        last_res = e;
        cyc();
        bus.result_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({bus.busy, bus.layer_start, bus.done} !== 3'b000 || (starts - l0) !== 1) begin
                bad++;
                $display("FAIL bp_no_queue%0d got busy=%b ls=%b done=%b starts=%0d required 0 0 0 1",
                         i, bus.busy, bus.layer_start, bus.done, starts - l0);
            end
            cyc();
        end
    endtask

    task automatic test_abort();
        res_t r, e;
        res_t prev = last_res;
        cyc();
        start_run(2'b10);
        feed(8'sd9);
        cyc();
        feed(-8'sd9);
        cyc();
        feed(8'sh7E);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.result_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.layer_data_valid, bus.done} !== 2'b10) begin
            bad++;
            $display("FAIL abort_cycle got ldv=%b done=%b required 1 0", bus.layer_data_valid, bus.done);
        end
        cyc();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        idle_in();
        @(negedge clk);
        r = got_res();
        total++;
        if ({bus.busy, bus.result_valid, bus.done, bus.layer_start, bus.pixel_count, r}
            !== {4'b0000, 8'd2, prev}) begin
            bad++;
            $display("FAIL abort_idle got busy=%b rv=%b done=%b ls=%b cnt=%0d res=%h required 0 0 0 0 2 %h",
                     bus.busy, bus.result_valid, bus.done, bus.layer_start, bus.pixel_count, r, prev);
        end
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.layer_start !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart_clear got ls=%b required 1", bus.layer_start);
        end
        cyc();
        for (int i = 0; i < NP; i++) begin
            feed(8'(100 + i));
            @(negedge clk);
            total++;
            if (bus.pixel_count !== 8'(i)) begin
                bad++;
                $display("FAIL abort_recount%0d got cnt=%0d required %0d", i, bus.pixel_count, i);
            end
            cyc();
        end
        idle_in();
        stub({8'h81, 8'h02, 8'h03, 8'hFF});
        cyc();
        junk();
        bus.result_ready = 1'b1;
        @(negedge clk);
        e = res_q.pop_front();
        r = got_res();
        total++;
        if ({bus.result_valid, bus.done, r} !== {2'b11, e}) begin
            bad++;
            $display("FAIL abort_next_result got rv=%b done=%b res=%h required 1 1 %h",
                     bus.result_valid, bus.done, r, e);
        end
        last_res = e;
        cyc();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int l0;
        res_t r, e;
        cyc();
        start_run(2'b01);
        for (int i = 0; i < 3; i++) begin
            feed(8'(40 + i));
            cyc();
        end
        l0 = starts;
        reset = 1'b1;
        bus.pixel_valid = 1'b1;
        bus.pixel_in = 8'sd9;
        bus.start = 1'b1;
        @(negedge clk);
        total++;
        if (all_outs() !== 56'd0) begin
            bad++;
            $display("FAIL rstmid_held got=%h required=0", all_outs());
        end
        cyc();
        reset = 1'b0;
        bus.start = 1'b0;
        idle_in();
        @(negedge clk);
        total++;
        if (all_outs() !== 56'd0 || starts !== l0) begin
            bad++;
            $display("FAIL rstmid_idle got=%h starts=%0d required 0 %0d", all_outs(), starts, l0);
        end
        last_res = '0;
        cyc();
        start_run(2'b11);
        for (int i = 0; i < NP; i++) begin
            feed(8'(-50 - i));
            cyc();
        end
        idle_in();
        stub({8'h10, 8'h20, 8'h30, 8'h40});
        cyc();
        junk();
        bus.result_ready = 1'b1;
        @(negedge clk);
        e = res_q.pop_front();
        r = got_res();
        total++;
        if ({bus.result_valid, bus.done, bus.layer_activation_type, r} !== {4'b1111, e}) begin
            bad++;
            $display("FAIL rstmid_rerun got rv=%b done=%b act=%b res=%h required 1 1 11 %h",
                     bus.result_valid, bus.done, bus.layer_activation_type, r, e);
        end
        last_res = e;
        cyc();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_config();
        res_t e;
        cyc();
        start_run(2'b01);
        for (int i = 0; i < NP; i++) begin
            feed(8'(i));
            if (i == 1) bus.activation_cfg = 2'b10;
            @(negedge clk);
            total++;
            if (bus.layer_activation_type !== 2'b01) begin
                bad++;
                $display("FAIL cfg_stream%0d got act=%b required 01", i, bus.layer_activation_type);
            end
            cyc();
        end
        idle_in();
        stub({8'h01, 8'h01, 8'h01, 8'h01});
        cyc();
        junk();
        bus.result_ready = 1'b1;
        @(negedge clk);
        e = res_q.pop_front();
        total++;
        if ({bus.done, got_res()} !== {1'b1, e}) begin
            bad++;
            $display("FAIL cfg_result got done=%b res=%h required 1 %h", bus.done, got_res(), e);
        end
        last_res = e;
        cyc();
        bus.result_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.layer_activation_type} !== 3'b001) begin
            bad++;
            $display("FAIL cfg_idle got busy=%b act=%b required 0 01", bus.busy, bus.layer_activation_type);
        end
        cyc();
        start_run(2'b10);
        @(negedge clk);
        total++;
        if ({bus.pixel_ready, bus.layer_activation_type} !== 3'b110) begin
            bad++;
            $display("FAIL cfg_relatch got prdy=%b act=%b required 1 10",
                     bus.pixel_ready, bus.layer_activation_type);
        end
        cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.layer_activation_type} !== 3'b010) begin
            bad++;
            $display("FAIL cfg_after_abort got busy=%b act=%b required 0 10",
                     bus.busy, bus.layer_activation_type);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.activation_cfg = 2'b00;
        bus.pixel_valid = 1'b0;
        bus.pixel_in = 8'sh00;
        bus.result_ready = 1'b0;
        bus.layer_out_n0 = 8'sh00;
        bus.layer_out_n1 = 8'sh00;
        bus.layer_out_n2 = 8'sh00;
        bus.layer_out_n3 = 8'sh00;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_config();
        cyc();
        total++;
        if (pix_q.size() != 0 || res_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got pixels=%0d results=%0d required 0 0",
                     pix_q.size(), res_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_controller.md
LAYER_CONTROLLER -- requirements
Module: layer_controller

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 64, pixels per image; legal range 1..256, since the layer weight address is 8 bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8 (`DATA_WIDTH), pixel and neuron output width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to run one image; sampled only in IDLE.
REQ-006 abort  input  1  cancel current run; return to IDLE, no result.
REQ-007 activation_cfg  input  2  activation type for the next run.
REQ-008 pixel_valid  input  1  source has a pixel on pixel_in.
REQ-009 pixel_in  input  DATA_WIDTH signed  pixel data.
REQ-010 pixel_ready  output  1  controller accepts pixel this cycle.
REQ-011 layer_start  output  1  clear pulse to the hidden layer (MAC clear and weight address reset).
REQ-012 layer_data_valid  output  1  pixel strobe to the hidden layer.
REQ-013 layer_pixel  output  DATA_WIDTH signed  pixel to the hidden layer.
REQ-014 layer_activation_type  output  2  latched activation type to the hidden layer.
REQ-015 layer_out_n0..n3  input  DATA_WIDTH signed each  activated neuron outputs from the hidden layer.
REQ-016 result_n0..n3  output  DATA_WIDTH signed each  captured neuron scores.
REQ-017 result_valid  output  1  results available.
REQ-018 result_ready  input  1  consumer takes results.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse on result handshake.
REQ-021 pixel_count  output  8  pixels accepted in the current run.

Function
REQ-022 SHALL implement the FSM IDLE, CLEAR, STREAM, SETTLE, RESULT, and no other states.
REQ-023 IDLE: when start=1 and abort=0, go to CLEAR; otherwise stay.
REQ-024 CLEAR lasts one cycle:
- layer_start=1; pixel_count<=0.
- activation_cfg is latched into layer_activation_type.
- Go to STREAM.
REQ-025 STREAM behaviour:
- pixel_ready=1.
- layer_data_valid = pixel_valid & pixel_ready, combinational.
- layer_pixel = pixel_in, combinational pass-through.
REQ-026 Each accepted pixel (pixel_valid=1 in STREAM) SHALL increment pixel_count by 1; acceptance with pixel_count==NUM_PIXELS-1 SHALL go to SETTLE.
REQ-027 Gaps (pixel_valid=0 in STREAM) SHALL hold state and count; there is no timeout.
REQ-028 SETTLE lasts one cycle: layer_out_n0..n3 are sampled at its closing edge into result_n0..n3; go to RESULT.
- The hidden layer's combinational activation of the final accumulator is valid during this cycle.
REQ-029 RESULT behaviour:
- result_valid=1; result_n* held stable.
- When result_ready=1: done=1 that cycle, then go to IDLE.
REQ-030 result_n* SHALL retain their values after the RESULT handshake until the next SETTLE capture.
REQ-031 pixel_ready, layer_data_valid and layer_start SHALL be 0 in every state not listed for them.
REQ-032 layer_pixel SHALL be 0 outside STREAM.
REQ-033 Latency: start to layer_start is 1 cycle; last accepted pixel to result_valid is 2 cycles.
REQ-034 start while busy SHALL be ignored and not queued.
REQ-035 abort=1 in any non-IDLE state SHALL go to IDLE at the next edge:
- No capture; done stays 0; result_valid=0.
- pixel_count holds its value.
REQ-036 abort overrides start and result_ready in the same cycle; abort in STREAM with pixel_valid=1 SHALL still present that pixel's layer_data_valid combinationally, and the next run's CLEAR discards it.
REQ-037 NUM_PIXELS=1: one accepted pixel SHALL go straight to SETTLE.
REQ-038 pixel_count SHALL NOT wrap; at NUM_PIXELS=256 the final acceptance SHALL leave it at 255 and exit STREAM.
REQ-039 layer_activation_type SHALL NOT change outside CLEAR.

Reset
REQ-040 reset=1 at any edge SHALL force IDLE, with these register values:
- pixel_count=0, result_n0..n3=0, result_valid=0, done=0.
- layer_activation_type=0.
REQ-041 While reset is asserted, all outputs SHALL be 0, including layer_start, layer_data_valid and pixel_ready.
REQ-042 Reset mid-run SHALL NOT issue layer_start; the next start SHALL issue it normally.

Verification
REQ-043 Basic run. NUM_PIXELS=4, start pulse, pixels 1,2,3,4 back-to-back, stub layer_out_n0..n3=8'h2A,8'h01,8'hF0,8'h00 during SETTLE -> exactly one layer_start cycle; 4 layer_data_valid cycles; result_valid 2 cycles after pixel 4; result_n*=2A,01,F0,00; done on result_ready.
REQ-044 Gapped stream. pixel_valid pattern 1,0,0,1,1,0,1 -> exactly 4 strobes; pixel_count steps 1..4; SETTLE entered only after the 4th strobe.
REQ-045 Backpressure. Hold result_ready=0 for 10 cycles -> result_valid and result_n* stable throughout; pixel_ready=0; start pulses ignored; done only on the cycle result_ready=1.
REQ-046 Abort. Abort after 2 pixels -> IDLE next cycle; no done; result_n* keep prior values; next run issues layer_start and counts from 0.
REQ-047 Reset mid-STREAM. Reset with pixel_count=3 -> next edge IDLE, all outputs 0; a following run completes normally.
REQ-048 Config latch. Change activation_cfg from 2'b01 to 2'b10 during STREAM -> layer_activation_type stays 2'b01 until the next CLEAR.
